// File: rtl/dmem_cache_pkg.sv
// Shared types and width helpers for the dmem_cache data cache.
package dmem_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Byte 0 is the least significant byte of the word.
    typedef logic [3:0][7:0] word_t;

    // SETS must be a power of two, at least 2.
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return 30 - $clog2(sets);
    endfunction

    function automatic int cnt_w(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/dmem_cache_if.sv
// Core-side and memory-side bus of dmem_cache; slave is the cache, master drives it.
// Handshake: the core holds read/write and addr/data_in until hit is seen high at a clock edge.
interface dmem_cache_if;

    logic [31:0]           addr;
    logic                  read;
    logic                  write;
    dmem_cache_pkg::word_t data_in;
    dmem_cache_pkg::word_t data_out;
    logic                  hit;
    logic [31:0]           mem_addr;
    dmem_cache_pkg::word_t mem_data_out;
    dmem_cache_pkg::word_t mem_data_in;
    logic                  mem_write_en;

    modport slave (
        input  addr, read, write, data_in, mem_data_out,
        output data_out, hit, mem_addr, mem_data_in, mem_write_en
    );

    modport master (
        output addr, read, write, data_in, mem_data_out,
        input  data_out, hit, mem_addr, mem_data_in, mem_write_en
    );

endinterface

// File: rtl/dmem_cache_array.sv
// Tag/valid/data storage: one synchronous write port, one combinational read port.
module dmem_cache_array
    import dmem_cache_pkg::*;
#(
    parameter int SETS = 32,
    parameter int IW   = index_w(SETS),
    parameter int TW   = tag_w(SETS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [TW-1:0] i_wtag,
    input  word_t         i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic          o_valid,
    output logic [TW-1:0] o_tag,
    output word_t         o_data
);

    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    word_t           r_data [SETS];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are never observed while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, write-allocate data cache with one-word lines.
// Defining DCACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dmem_cache
    import dmem_cache_pkg::*;
#(
    parameter int SETS    = 32,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    dmem_cache_if.slave bus,
    output state_t      o_dbg_state
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IW = index_w(SETS);
    localparam int TW = tag_w(SETS);
    localparam int CW = cnt_w(MEM_LAT);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [29:0]   r_waddr;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_valid;
    logic [TW-1:0] w_rtag;
    word_t         w_rdata;
    logic          w_line_hit;
    logic          w_load;
    logic          w_store;
    logic          w_last;
    logic          w_we;
    word_t         w_wdata;
    logic          w_unused_addr;

    assign w_idx         = bus.addr[IW+1:2];
    assign w_tag         = bus.addr[31:IW+2];
    assign w_unused_addr = ^bus.addr[1:0];

    // Both strobes together count as a store.
    assign w_store    = bus.write;
    assign w_load     = bus.read && !bus.write;
    assign w_line_hit = w_valid && (w_rtag == w_tag);
    assign w_last     = (r_state != ST_IDLE) && (r_cnt == LAST);

    dmem_cache_array #(.SETS(SETS)) u_array (
        .clk    (clk),
        .rst_b  (rst_b),
        .i_we   (w_we),
        .i_widx (r_waddr[IW-1:0]),
        .i_wtag (r_waddr[29:IW]),
        .i_wdata(w_wdata),
        .i_ridx (w_idx),
        .o_valid(w_valid),
        .o_tag  (w_rtag),
        .o_data (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_cnt   <= '0;
            r_waddr <= '0;
        end else begin
            if (r_state == ST_IDLE || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == ST_IDLE && w_next != ST_IDLE) begin
                r_waddr <= bus.addr[31:2];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_store || w_load) begin
                    if (!w_line_hit) begin
                        w_next = ST_FILL;
                    end else if (w_store) begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_FILL:  if (w_last) w_next = ST_IDLE;
            ST_WRITE: if (w_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Everything toward memory and the core is forced quiet while reset is held.
    always_comb begin
        bus.hit          = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        w_we             = 1'b0;
        w_wdata          = '0;
        if (!rst_b) begin
            case (r_state)
                ST_IDLE: begin
                    bus.hit = w_load && w_line_hit;
                end
                ST_FILL: begin
                    bus.mem_addr = {r_waddr, 2'b00};
                    w_we         = w_last;
                    w_wdata      = bus.mem_data_out;
                end
                ST_WRITE: begin
                    bus.mem_addr     = {r_waddr, 2'b00};
                    bus.mem_data_in  = bus.data_in;
                    bus.mem_write_en = 1'b1;
                    bus.hit          = w_last;
                    w_we             = w_last;
                    w_wdata          = bus.data_in;
                end
                default: ;
            endcase
        end
    end

    // The line keeps showing its old contents during WRITE so the core can merge sub-word stores.
    assign bus.data_out = w_valid ? w_rdata : '0;
    assign o_dbg_state  = r_state;

`ifdef DCACHE_STATS_EN
    logic        r_missed;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // r_missed keeps the post-fill completion of a miss out of the hit count.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_missed   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_next == ST_FILL) begin
                r_missed <= 1'b1;
                if (r_miss_cnt != 32'hFFFF_FFFF) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end else if (bus.hit) begin
                r_missed <= 1'b0;
            end
            if (r_state == ST_IDLE && bus.hit && !r_missed && r_hit_cnt != 32'hFFFF_FFFF) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: latency, data, write-through traffic and reset abort.
// Build with DCACHE_STATS_EN to also exercise the hit/miss counters.
module tb_dmem_cache;
    import dmem_cache_pkg::*;

    localparam int MEM_LAT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    dmem_cache_if bif ();
    state_t dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dmem_cache #(.SETS(32), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bus        (bif),
        .o_dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- memory model + scoreboard ----------------
    word_t       mem_arr [256];
    int          hold = 0;
    logic [31:0] prev_addr = '0;
    int          we_cycles = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_aq [$];
    logic [31:0] ea;
    logic [31:0] ed;

    // Read data is only valid once the address has been held for MEM_LAT cycles.
    assign bif.mem_data_out = (hold >= MEM_LAT && bif.mem_addr == prev_addr)
                              ? mem_arr[bif.mem_addr[9:2]] : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        hold = (bif.mem_addr == prev_addr) ? hold + 1 : 1;
        prev_addr = bif.mem_addr;
        if (bif.mem_write_en === 1'b1) begin
            we_cycles++;
            if (hold == MEM_LAT) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write_unexpected addr=%h data=%h", bif.mem_addr, bif.mem_data_in);
                end else begin
                    ea = exp_aq.pop_front();
                    ed = exp_q.pop_front();
                    if (bif.mem_addr !== ea || bif.mem_data_in !== ed) begin
                        errors++;
                        $display("FAIL mem_write got addr=%h data=%h exp addr=%h data=%h",
                                 bif.mem_addr, bif.mem_data_in, ea, ed);
                    end
                end
                mem_arr[bif.mem_addr[9:2]] = bif.mem_data_in;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic rd, input logic wr,
                          input word_t din, output int lat, output word_t dout);
        int   n;
        logic done;
        @(posedge clk); #1;
        bif.addr = a;
        bif.read = rd;
        bif.write = wr;
        bif.data_in = din;
        n = 0;
        done = 1'b0;
        dout = '0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (bif.hit === 1'b1) begin
                done = 1'b1;
                dout = bif.data_out;
            end
            @(posedge clk); #1;
        end
        bif.read = 1'b0;
        bif.write = 1'b0;
        lat = done ? n : -1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bif.addr = 32'h100;
        bif.read = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bif.hit); end
        checks++; if (bif.mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", bif.mem_write_en); end
        checks++; if (bif.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bif.mem_addr); end
        @(posedge clk); #1;
        rst_b = 1'b0;
        bif.read = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
        checks++; if (bif.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h exp 0", bif.data_out); end
        checks++; if (bif.mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr got %h exp 0", bif.mem_addr); end
    endtask

    task automatic test_load_miss_hit();
        int lat; word_t dout; int w0;
        w0 = we_cycles;
        do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 6) begin errors++; $display("FAIL load_miss_latency got %0d exp 6", lat); end
        checks++; if (dout !== 32'h1122_3344) begin errors++; $display("FAIL load_miss_data got %h exp 11223344", dout); end
        checks++; if (dout[0] !== 8'h44) begin errors++; $display("FAIL load_byte0 got %h exp 44", dout[0]); end
        do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 1) begin errors++; $display("FAIL load_hit_latency got %0d exp 1", lat); end
        checks++; if (dout !== 32'h1122_3344) begin errors++; $display("FAIL load_hit_data got %h exp 11223344", dout); end
        checks++; if (we_cycles - w0 !== 0) begin errors++; $display("FAIL load_no_write got %0d exp 0", we_cycles - w0); end
    endtask

    task automatic test_store_hit();
        int lat; word_t dout; int w0;
        exp_aq.push_back(32'h100);
        exp_q.push_back(32'hDEAD_BEEF);
        w0 = we_cycles;
        do_req(32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF, lat, dout);
        checks++; if (lat !== 5) begin errors++; $display("FAIL store_hit_latency got %0d exp 5", lat); end
        checks++; if (dout !== 32'h1122_3344) begin errors++; $display("FAIL store_old_line got %h exp 11223344", dout); end
        checks++; if (we_cycles - w0 !== 4) begin errors++; $display("FAIL store_we_cycles got %0d exp 4", we_cycles - w0); end
        do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 1) begin errors++; $display("FAIL store_reload_latency got %0d exp 1", lat); end
        checks++; if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_reload_data got %h exp deadbeef", dout); end
    endtask

    task automatic test_conflict();
        int lat; word_t dout;
        do_req(32'h180, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 6) begin errors++; $display("FAIL conflict_latency got %0d exp 6", lat); end
        checks++; if (dout !== 32'h5566_7788) begin errors++; $display("FAIL conflict_data got %h exp 55667788", dout); end
        do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 6) begin errors++; $display("FAIL evicted_latency got %0d exp 6", lat); end
        checks++; if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL evicted_data got %h exp deadbeef", dout); end
    endtask

    task automatic test_store_miss();
        int lat; word_t dout; int w0;
        exp_aq.push_back(32'h204);
        exp_q.push_back(32'hAABB_CC55);
        w0 = we_cycles;
        do_req(32'h204, 1'b0, 1'b1, 32'hAABB_CC55, lat, dout);
        checks++; if (lat !== 10) begin errors++; $display("FAIL store_miss_latency got %0d exp 10", lat); end
        checks++; if (dout !== 32'hAABB_CCDD) begin errors++; $display("FAIL store_miss_old_line got %h exp aabbccdd", dout); end
        checks++; if (we_cycles - w0 !== 4) begin errors++; $display("FAIL store_miss_we_cycles got %0d exp 4", we_cycles - w0); end
        do_req(32'h204, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 1) begin errors++; $display("FAIL store_miss_reload_latency got %0d exp 1", lat); end
        checks++; if (dout !== 32'hAABB_CC55) begin errors++; $display("FAIL store_miss_reload_data got %h exp aabbcc55", dout); end
    endtask

    task automatic test_read_write_both();
        int lat; word_t dout; int w0;
        exp_aq.push_back(32'h204);
        exp_q.push_back(32'h0102_0304);
        w0 = we_cycles;
        do_req(32'h204, 1'b1, 1'b1, 32'h0102_0304, lat, dout);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rw_both_latency got %0d exp 5", lat); end
        checks++; if (we_cycles - w0 !== 4) begin errors++; $display("FAIL rw_both_we_cycles got %0d exp 4", we_cycles - w0); end
        do_req(32'h204, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (dout !== 32'h0102_0304) begin errors++; $display("FAIL rw_both_data got %h exp 01020304", dout); end
    endtask

    task automatic test_reset_mid_fill();
        int lat; word_t dout;
        @(posedge clk); #1;
        bif.addr = 32'h300;
        bif.read = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dbg_state !== ST_FILL) begin errors++; $display("FAIL fill_entered got %0d exp %0d", dbg_state, ST_FILL); end
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        checks++; if (bif.mem_write_en !== 1'b0) begin errors++; $display("FAIL abort_fill_we got %b exp 0", bif.mem_write_en); end
        checks++; if (bif.hit !== 1'b0) begin errors++; $display("FAIL abort_fill_hit got %b exp 0", bif.hit); end
        checks++; if (bif.mem_addr !== 32'h0) begin errors++; $display("FAIL abort_fill_mem_addr got %h exp 0", bif.mem_addr); end
        @(posedge clk); #1;
        rst_b = 1'b0;
        bif.read = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_fill_state got %0d exp %0d", dbg_state, ST_IDLE); end
        checks++; if (bif.data_out !== 32'h0) begin errors++; $display("FAIL abort_fill_line got %h exp 0", bif.data_out); end
        do_req(32'h300, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 6) begin errors++; $display("FAIL after_abort_latency got %0d exp 6", lat); end
        checks++; if (dout !== 32'h0BAD_F00D) begin errors++; $display("FAIL after_abort_data got %h exp 0badf00d", dout); end
    endtask

    task automatic test_reset_mid_write();
        int lat; word_t dout; int w0;
        w0 = we_cycles;
        @(posedge clk); #1;
        bif.addr = 32'h300;
        bif.write = 1'b1;
        bif.data_in = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bif.mem_write_en !== 1'b1) begin errors++; $display("FAIL write_strobe_on got %b exp 1", bif.mem_write_en); end
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        checks++; if (bif.mem_write_en !== 1'b0) begin errors++; $display("FAIL abort_write_we got %b exp 0", bif.mem_write_en); end
        @(posedge clk); #1;
        rst_b = 1'b0;
        bif.write = 1'b0;
        checks++; if (we_cycles - w0 !== 1) begin errors++; $display("FAIL abort_write_we_cycles got %0d exp 1", we_cycles - w0); end
        do_req(32'h300, 1'b1, 1'b0, '0, lat, dout);
        checks++; if (lat !== 6) begin errors++; $display("FAIL abort_write_reload_latency got %0d exp 6", lat); end
        checks++; if (dout !== 32'h0BAD_F00D) begin errors++; $display("FAIL abort_write_reload_data got %h exp 0badf00d", dout); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        int lat; word_t dout;
        pulse_reset();
        do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        for (int i = 0; i < 3; i++) begin
            do_req(32'h100, 1'b1, 1'b0, '0, lat, dout);
        end
        do_req(32'h180, 1'b1, 1'b0, '0, lat, dout);
        @(negedge clk);
        checks++; if (hit_cnt !== 32'd3) begin errors++; $display("FAIL stats_hit_cnt got %0d exp 3", hit_cnt); end
        checks++; if (miss_cnt !== 32'd2) begin errors++; $display("FAIL stats_miss_cnt got %0d exp 2", miss_cnt); end
        pulse_reset();
        @(negedge clk);
        checks++; if (hit_cnt !== 32'd0) begin errors++; $display("FAIL stats_hit_reset got %0d exp 0", hit_cnt); end
        checks++; if (miss_cnt !== 32'd0) begin errors++; $display("FAIL stats_miss_reset got %0d exp 0", miss_cnt); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[8'h40] = 32'h1122_3344;
        mem_arr[8'h60] = 32'h5566_7788;
        mem_arr[8'h81] = 32'hAABB_CCDD;
        mem_arr[8'hC0] = 32'h0BAD_F00D;
        bif.addr = '0;
        bif.read = 1'b0;
        bif.write = 1'b0;
        bif.data_in = '0;

        test_reset();
        test_load_miss_hit();
        test_store_hit();
        test_conflict();
        test_store_miss();
        test_read_write_both();
        test_reset_mid_fill();
        test_reset_mid_write();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
